conv_psum_collector: RTL and testbench
======================================

CONV_PSUM_COLLECTOR -- requirements
Module: conv_psum_collector

Interface
REQ-001 Parameter: TAPS, default 3, number of psum beats summed per output pixel; legal range 1..16.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  single-cycle pulse; begins a new collection.
REQ-005 psum_in1, psum_in2  input  8 each  unsigned psum from systolic-array column 1 / column 2.
REQ-006 psum_valid1, psum_valid2  input  1 each  per-column beat qualifiers; column 2 may lag column 1 by any skew.
REQ-007 out_ack  input  1  consumer accepts held result.
REQ-008 out_11, out_12, out_21, out_22  output  8 each  registered 2x2 output map.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 done  output  1  one-cycle pulse when a result becomes valid.
REQ-011 busy  output  1  high while in COLLECT.
REQ-012 overrun  output  1  sticky flag: a valid beat arrived and was discarded.

Function
REQ-013 FSM states: IDLE, COLLECT, HOLD; busy = (state==COLLECT), out_valid = (state==HOLD).
REQ-014 IDLE: start -> COLLECT next cycle, clearing all four 12-bit accumulators and both column beat counters.
REQ-015 Beats are accepted only in COLLECT; a valid beat in IDLE, in HOLD, or in the cycle start is sampled in IDLE is discarded.
REQ-016 Each column has a beat counter 0..2*TAPS; a beat with count<TAPS adds to the row-1 pixel (col1->11, col2->12); TAPS<=count<2*TAPS adds to the row-2 pixel (col1->21, col2->22).
REQ-017 Column 1 and column 2 beats in the same cycle are both accepted independently.
REQ-018 A column whose counter equals 2*TAPS is complete; further beats on it are discarded.
REQ-019 Accumulation is unsigned, 12 bits, zero-extended from 8-bit input; no overflow possible for TAPS<=16.
REQ-020 On the edge accepting the final beat that completes both columns: state->HOLD, out_* loaded from final sums (including that beat) via REQ-028 conversion, done=1 for exactly that next cycle.
REQ-021 Latency: out_valid and done rise one cycle after the last accepted beat's clock edge.
REQ-022 out_* change only on HOLD entry; otherwise hold their previous value.
REQ-023 HOLD: out_ack -> IDLE next cycle; out_valid drops that cycle.
REQ-024 HOLD with start and out_ack in the same cycle -> COLLECT directly with cleared accumulators; start without out_ack in HOLD is ignored.
REQ-025 start in COLLECT restarts: accumulators and counters cleared, beats that cycle discarded, state stays COLLECT.
REQ-026 overrun sets on any discarded valid beat (REQ-015, REQ-018, REQ-025); clears only on an accepted start or reset; a discard and a clearing start in the same cycle leave overrun=1.

Reset
REQ-027 rst asserted: state=IDLE, accumulators=0, counters=0, out_*=0, out_valid=0, done=0, busy=0, overrun=0, effective immediately, including mid-COLLECT or mid-HOLD; partial results are lost.

Configuration
REQ-028 Macro CONV_PSUM_SAT_EN: defined -> each 12-bit sum above 255 is output as 255; undefined -> output is the low 8 bits of the sum (wrap).
REQ-029 The macro affects only the REQ-020 conversion; FSM, counters and flags are identical in both builds.

Verification
REQ-030 TAPS=3; start; col1 beats 10,20,30,1,2,3; col2 same values delayed 1 cycle: 100,100,100,5,5,5 -> out_11=60, out_21=6, out_22=15, out_12=255 (SAT_EN) or 44 (no SAT_EN); done one cycle, out_valid held until out_ack.
REQ-031 After col1 completes, one extra psum_valid1 beat of 50 -> discarded, out_11/out_21 unchanged, overrun=1 until next start.
REQ-032 Assert rst after 2 col1 beats -> all outputs 0 immediately; new start then full sequence of REQ-030 -> same results as REQ-030.
REQ-033 start re-pulsed in COLLECT after 4 beats, then full REQ-030 sequence -> results equal REQ-030, earlier beats not included.
REQ-034 In HOLD, start alone -> ignored, out_valid stays 1; start with out_ack -> busy=1 next cycle, out_* keep prior values until next done.
REQ-035 TAPS=1; col1 7,9 and col2 8,255 in the same cycles -> out_11=7, out_21=9, out_12=8, out_22=255, done one cycle after the second beat pair.

Source files
------------

// File: rtl/conv_psum_collector.sv
// Collects skewed psum beats from two systolic-array columns into a registered 2x2 output map.
// Define CONV_PSUM_SAT_EN to saturate each output pixel at 255 instead of wrapping to 8 bits.
module conv_psum_collector #(
    parameter int TAPS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] psum_in1,
    input  logic [7:0] psum_in2,
    input  logic       psum_valid1,
    input  logic       psum_valid2,
    input  logic       out_ack,
    output logic [7:0] out_11,
    output logic [7:0] out_12,
    output logic [7:0] out_21,
    output logic [7:0] out_22,
    output logic       out_valid,
    output logic       done,
    output logic       busy,
    output logic       overrun
);

    localparam int CW = $clog2(2 * TAPS + 1);
    localparam logic [CW-1:0] ROW2 = CW'(TAPS);
    localparam logic [CW-1:0] FULL = CW'(2 * TAPS);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t        state_q, state_d;
    logic [11:0]   acc11_q, acc12_q, acc21_q, acc22_q;
    logic [11:0]   acc11_d, acc12_d, acc21_d, acc22_d;
    logic [CW-1:0] cnt1_q, cnt2_q, cnt1_d, cnt2_d;
    logic [7:0]    out11_q, out12_q, out21_q, out22_q;
    logic          done_q, overrun_q, overrun_d;
    logic          clear, accept1, accept2, discard, finish;

    function automatic logic [7:0] to_pixel(input logic [11:0] sum);
`ifdef CONV_PSUM_SAT_EN
        return (sum > 12'd255) ? 8'hff : sum[7:0];
`else
        return sum[7:0];
`endif
    endfunction

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        acc11_d = acc11_q;
        acc12_d = acc12_q;
        acc21_d = acc21_q;
        acc22_d = acc22_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        state_d = state_q;

        clear   = start && ((state_q == IDLE) || (state_q == COLLECT) ||
                            (state_q == HOLD && out_ack));
        accept1 = (state_q == COLLECT) && !start && psum_valid1 && (cnt1_q != FULL);
        accept2 = (state_q == COLLECT) && !start && psum_valid2 && (cnt2_q != FULL);
        discard = (psum_valid1 && !accept1) || (psum_valid2 && !accept2);

        if (clear) begin
            acc11_d = '0;
            acc12_d = '0;
            acc21_d = '0;
            acc22_d = '0;
            cnt1_d  = '0;
            cnt2_d  = '0;
        end else begin
            if (accept1) begin
                if (cnt1_q < ROW2) acc11_d = acc11_q + 12'(psum_in1);
                else               acc21_d = acc21_q + 12'(psum_in1);
                cnt1_d = cnt1_q + 1'b1;
            end
            if (accept2) begin
                if (cnt2_q < ROW2) acc12_d = acc12_q + 12'(psum_in2);
                else               acc22_d = acc22_q + 12'(psum_in2);
                cnt2_d = cnt2_q + 1'b1;
            end
        end

        // Only an accepted beat can complete the map, so a stale full pair never re-fires.
        finish = (accept1 || accept2) && (cnt1_d == FULL) && (cnt2_d == FULL);

        case (state_q)
            IDLE:    if (start) state_d = COLLECT;
            COLLECT: if (start) state_d = COLLECT;
                     else if (finish) state_d = HOLD;
            HOLD:    if (out_ack) state_d = start ? COLLECT : IDLE;
            default: state_d = IDLE;
        endcase

        // A discard in the same cycle as a clearing start must survive the clear.
        overrun_d = clear ? discard : (overrun_q || discard);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc11_q   <= '0;
            acc12_q   <= '0;
            acc21_q   <= '0;
            acc22_q   <= '0;
            cnt1_q    <= '0;
            cnt2_q    <= '0;
            out11_q   <= '0;
            out12_q   <= '0;
            out21_q   <= '0;
            out22_q   <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc11_q   <= acc11_d;
            acc12_q   <= acc12_d;
            acc21_q   <= acc21_d;
            acc22_q   <= acc22_d;
            cnt1_q    <= cnt1_d;
            cnt2_q    <= cnt2_d;
            done_q    <= finish;
            overrun_q <= overrun_d;
            if (finish) begin
                out11_q <= to_pixel(acc11_d);
                out12_q <= to_pixel(acc12_d);
                out21_q <= to_pixel(acc21_d);
                out22_q <= to_pixel(acc22_d);
            end
        end
    end

    assign out_11    = out11_q;
    assign out_12    = out12_q;
    assign out_21    = out21_q;
    assign out_22    = out22_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_conv_psum_collector.sv
// Self-checking bench for conv_psum_collector: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model (TAPS=3 and TAPS=1 instances).
module tb_conv_psum_collector;

    localparam int T = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start, v1, v2, ack;
    logic [7:0] p1, p2;
    logic [7:0] o11, o12, o21, o22;
    logic       ov, dn, bz, orun;

    logic       b_start, b_v1, b_v2, b_ack;
    logic [7:0] b_p1, b_p2;
    logic [7:0] b_o11, b_o12, b_o21, b_o22;
    logic       b_ov, b_dn, b_bz, b_orun;

    conv_psum_collector #(.TAPS(T)) dut (
        .clk(clk), .rst(rst), .start(start),
        .psum_in1(p1), .psum_in2(p2), .psum_valid1(v1), .psum_valid2(v2), .out_ack(ack),
        .out_11(o11), .out_12(o12), .out_21(o21), .out_22(o22),
        .out_valid(ov), .done(dn), .busy(bz), .overrun(orun)
    );

    conv_psum_collector #(.TAPS(1)) dut1 (
        .clk(clk), .rst(rst), .start(b_start),
        .psum_in1(b_p1), .psum_in2(b_p2), .psum_valid1(b_v1), .psum_valid2(b_v2), .out_ack(b_ack),
        .out_11(b_o11), .out_12(b_o12), .out_21(b_o21), .out_22(b_o22),
        .out_valid(b_ov), .done(b_dn), .busy(b_bz), .overrun(b_orun)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: beats held in per-column queues, pixels computed as plain sums.
    int         m_mode;  // 0 idle, 1 collecting, 2 holding
    int         q1[$];
    int         q2[$];
    logic [7:0] m_o[4];
    logic       m_done, m_ovr;

    function automatic logic [7:0] conv(input int s);
`ifdef CONV_PSUM_SAT_EN
        return (s > 255) ? 8'd255 : 8'(s);
`else
        return 8'(s);
`endif
    endfunction

    function automatic int qsum(input int q[$], input int lo, input int hi);
        int s = 0;
        for (int i = lo; i < hi; i++) s += q[i];
        return s;
    endfunction

    task automatic m_reset();
        m_mode = 0;
        q1.delete();
        q2.delete();
        for (int i = 0; i < 4; i++) m_o[i] = 8'd0;
        m_done = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic m_step(input bit st, input bit a1, input int d1, input bit a2, input int d2,
                          input bit k);
        bit disc = 1'b0;
        bit clr  = 1'b0;
        m_done = 1'b0;
        case (m_mode)
            0: begin
                disc = a1 | a2;
                clr  = st;
            end
            1: begin
                if (st) begin
                    clr  = 1'b1;
                    disc = a1 | a2;
                end else begin
                    if (a1) begin
                        if (q1.size() < 2 * T) q1.push_back(d1);
                        else disc = 1'b1;
                    end
                    if (a2) begin
                        if (q2.size() < 2 * T) q2.push_back(d2);
                        else disc = 1'b1;
                    end
                    if ((a1 || a2) && q1.size() == 2 * T && q2.size() == 2 * T) begin
                        m_mode = 2;
                        m_done = 1'b1;
                        m_o[0] = conv(qsum(q1, 0, T));
                        m_o[1] = conv(qsum(q2, 0, T));
                        m_o[2] = conv(qsum(q1, T, 2 * T));
                        m_o[3] = conv(qsum(q2, T, 2 * T));
                    end
                end
            end
            default: begin
                disc = a1 | a2;
                if (k) begin
                    if (st) clr = 1'b1;
                    else m_mode = 0;
                end
            end
        endcase
        if (clr) begin
            q1.delete();
            q2.delete();
            m_mode = 1;
            m_ovr  = disc;
        end else begin
            m_ovr = m_ovr | disc;
        end
    endtask

    task automatic cyc(input bit st, input bit a1, input int d1, input bit a2, input int d2,
                       input bit k);
        start = st; v1 = a1; p1 = 8'(d1); v2 = a2; p2 = 8'(d2); ack = k;
        m_step(st, a1, d1, a2, d2, k);
        @(posedge clk);
        #1;
        check("cycle", {o11, o12, o21, o22, ov, dn, bz, orun},
              {m_o[0], m_o[1], m_o[2], m_o[3], m_mode == 2, m_done, m_mode == 1, m_ovr});
        start = 1'b0; v1 = 1'b0; v2 = 1'b0; ack = 1'b0;
    endtask

    int c1[6] = '{10, 20, 30, 1, 2, 3};
    int c2[6] = '{100, 100, 100, 5, 5, 5};

    task automatic run030(input bit extra50);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            int j = (i >= 1) ? i - 1 : 0;
            cyc(0, (i < 6) || extra50, (i < 6) ? c1[i] : 50, i >= 1, c2[j], 0);
        end
    endtask

    task automatic check030(input string tag);
        check({tag, " out_11"}, o11, 60);
`ifdef CONV_PSUM_SAT_EN
        check({tag, " out_12"}, o12, 255);
`else
        check({tag, " out_12"}, o12, 44);
`endif
        check({tag, " out_21"}, o21, 6);
        check({tag, " out_22"}, o22, 15);
    endtask

    typedef struct {
        bit       st;
        bit       a1;
        int       d1;
        bit       a2;
        int       d2;
        bit       k;
        bit       e_busy;
        bit       e_valid;
        bit       e_done;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt = '{
            '{1, 0, 0,  0, 0,   0, 1, 0, 0},
            '{0, 1, 10, 0, 0,   0, 1, 0, 0},
            '{0, 1, 20, 1, 100, 0, 1, 0, 0},
            '{0, 1, 30, 1, 100, 0, 1, 0, 0},
            '{0, 1, 1,  1, 100, 0, 1, 0, 0},
            '{0, 1, 2,  1, 5,   0, 1, 0, 0},
            '{0, 1, 3,  1, 5,   0, 1, 0, 0},
            '{0, 0, 0,  1, 5,   0, 0, 1, 1},
            '{0, 0, 0,  0, 0,   0, 0, 1, 0},
            '{0, 0, 0,  0, 0,   1, 0, 0, 0}
        };

        rst = 1'b1;
        start = 0; v1 = 0; v2 = 0; ack = 0; p1 = 0; p2 = 0;
        b_start = 0; b_v1 = 0; b_v2 = 0; b_ack = 0; b_p1 = 0; b_p2 = 0;
        m_reset();
        #12;
        check("reset dut", {o11, o12, o21, o22, ov, dn, bz, orun}, 36'd0);
        check("reset dut1", {b_o11, b_o12, b_o21, b_o22, b_ov, b_dn, b_bz, b_orun}, 36'd0);
        rst = 1'b0;

        // TAPS=1: two beat pairs in lockstep complete the map.
        b_start = 1'b1;
        @(posedge clk); #1;
        check("t1 busy", b_bz, 1);
        b_start = 1'b0; b_v1 = 1; b_p1 = 7; b_v2 = 1; b_p2 = 8;
        @(posedge clk); #1;
        check("t1 first pair", {b_ov, b_dn, b_bz}, 3'b001);
        b_p1 = 9; b_p2 = 255;
        @(posedge clk); #1;
        b_v1 = 0; b_v2 = 0;
        check("t1 done", {b_ov, b_dn, b_bz, b_orun}, 4'b1100);
        check("t1 map", {b_o11, b_o12, b_o21, b_o22}, {8'd7, 8'd8, 8'd9, 8'd255});
        @(posedge clk); #1;
        check("t1 done drop", {b_ov, b_dn}, 2'b10);
        b_ack = 1;
        @(posedge clk); #1;
        b_ack = 0;
        check("t1 ack", {b_ov, b_bz}, 2'b00);

        // Basic collection, cycle-by-cycle control expectations.
        for (int i = 0; i < 10; i++) begin
            cyc(vt[i].st, vt[i].a1, vt[i].d1, vt[i].a2, vt[i].d2, vt[i].k);
            check($sformatf("vec %0d busy/valid/done", i), {bz, ov, dn},
                  {vt[i].e_busy, vt[i].e_valid, vt[i].e_done});
        end
        check030("basic");
        check("basic no overrun", orun, 0);

        // Extra beat on a completed column is dropped and flagged until the next start.
        run030(1);
        check030("extra");
        check("extra overrun", orun, 1);
        cyc(0, 0, 0, 0, 0, 1);
        check("overrun sticky", orun, 1);
        cyc(1, 0, 0, 0, 0, 0);
        check("overrun cleared", orun, 0);

        // Reset mid-collection clears everything immediately.
        cyc(0, 1, 10, 0, 0, 0);
        cyc(0, 1, 20, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("async reset", {o11, o12, o21, o22, ov, dn, bz, orun}, 36'd0);
        m_reset();
        #2 rst = 1'b0;
        run030(0);
        check030("after reset");
        cyc(0, 0, 0, 0, 0, 1);

        // Restart mid-collection discards earlier beats.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 10, 0, 0, 0);
        cyc(0, 1, 20, 1, 100, 0);
        cyc(0, 1, 30, 0, 0, 0);
        run030(0);
        check030("restart");

        // HOLD: start alone ignored; start with ack restarts while outputs persist.
        cyc(1, 0, 0, 0, 0, 0);
        check("hold start ignored", {ov, bz}, 2'b10);
        cyc(1, 0, 0, 0, 0, 1);
        check("hold start+ack busy", {ov, bz}, 2'b01);
        check("hold outputs kept", o11, 60);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 1, 1, 2, 0);
            if (i == 4) check("outputs before done", o22, 15);
        end
        check("new map", {o11, o12, o21, o22, dn}, {8'd3, 8'd6, 8'd3, 8'd6, 1'b1});
        cyc(0, 0, 0, 0, 0, 1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 255),
                $urandom_range(0, 1) == 1, $urandom_range(0, 255), $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
